// File: rtl/spi_share_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ sensor FSMs.
// Applies the winner's SPI mode, muxes its strobes, and revokes a grant held too long.
module spi_share_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int GAP      = 2,
    parameter int HOLD_MAX = 1024
) (
    input  logic                   Clk_i,
    input  logic                   Reset_i,
    input  logic [NUM_REQ-1:0]     Req_i,
    output logic [NUM_REQ-1:0]     Grant_o,
    output logic [NUM_REQ-1:0]     Timeout_o,
    input  logic [NUM_REQ-1:0]     Req_Write_i,
    input  logic [NUM_REQ-1:0]     Req_ReadNext_i,
    input  logic [8*NUM_REQ-1:0]   Req_Data_i,
    input  logic [NUM_REQ-1:0]     Req_CPOL_i,
    input  logic [NUM_REQ-1:0]     Req_CPHA_i,
    input  logic [NUM_REQ-1:0]     Req_LSBFE_i,
    output logic                   SPI_Write_o,
    output logic                   SPI_ReadNext_o,
    output logic [7:0]             SPI_Data_o,
    output logic                   SPI_CPOL_o,
    output logic                   SPI_CPHA_o,
    output logic                   SPI_LSBFE_o,
    input  logic                   SPI_Transmission_i,
    input  logic                   SPI_FIFOEmpty_i,
    output logic                   Busy_o
);

    localparam int SEL_W = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GRANTED,
        ST_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic [15:0]          settleCnt_q, settleCnt_d;
    logic [15:0]          holdCnt_q, holdCnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   timeout_q, timeout_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;
    logic                 lsbfe_q, lsbfe_d;
    logic                 winValid;
    logic [SEL_W-1:0]     winSel;

    // Search starts just after the last served requester, giving round-robin fairness.
    always_comb begin
        winValid = 1'b0;
        winSel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!winValid && Req_i[(int'(last_q) + k) % NUM_REQ]) begin
                winValid = 1'b1;
                winSel   = SEL_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        settleCnt_d = settleCnt_q;
        holdCnt_d   = holdCnt_q;
        grant_d     = grant_q;
        timeout_d   = '0;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsbfe_d     = lsbfe_q;
        case (state_q)
            ST_IDLE: begin
                if (winValid) begin
                    sel_d   = winSel;
                    cpol_d  = Req_CPOL_i[winSel];
                    cpha_d  = Req_CPHA_i[winSel];
                    lsbfe_d = Req_LSBFE_i[winSel];
                    if (GAP == 0) begin
                        state_d         = ST_GRANTED;
                        holdCnt_d       = '0;
                        grant_d         = '0;
                        grant_d[winSel] = 1'b1;
                    end else begin
                        state_d     = ST_SETTLE;
                        settleCnt_d = 16'(GAP);
                    end
                end
            end
            ST_SETTLE: begin
                if (!Req_i[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (settleCnt_q == 16'd1) begin
                    state_d        = ST_GRANTED;
                    holdCnt_d      = '0;
                    grant_d        = '0;
                    grant_d[sel_q] = 1'b1;
                end else begin
                    settleCnt_d = settleCnt_q - 16'd1;
                end
            end
            ST_GRANTED: begin
                holdCnt_d = holdCnt_q + 16'd1;
                // A voluntary drop wins over a simultaneous watchdog expiry.
                if (!Req_i[sel_q]) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end else if (HOLD_MAX != 0 && holdCnt_q == HOLD_LAST) begin
                    state_d          = ST_RELEASE;
                    grant_d          = '0;
                    timeout_d[sel_q] = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!SPI_Transmission_i && SPI_FIFOEmpty_i) begin
                    state_d = ST_IDLE;
                    last_d  = sel_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            last_q      <= SEL_W'(NUM_REQ - 1);
            settleCnt_q <= '0;
            holdCnt_q   <= '0;
            grant_q     <= '0;
            timeout_q   <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsbfe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            settleCnt_q <= settleCnt_d;
            holdCnt_q   <= holdCnt_d;
            grant_q     <= grant_d;
            timeout_q   <= timeout_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsbfe_q     <= lsbfe_d;
        end
    end

    // Strobes reach the master only from the current holder.
    assign SPI_Write_o    = (state_q == ST_GRANTED) & Req_Write_i[sel_q];
    assign SPI_ReadNext_o = (state_q == ST_GRANTED) & Req_ReadNext_i[sel_q];
    assign SPI_Data_o     = (state_q == ST_GRANTED) ? Req_Data_i[int'(sel_q)*8 +: 8] : 8'h00;

    assign Grant_o     = grant_q;
    assign Timeout_o   = timeout_q;
    assign SPI_CPOL_o  = cpol_q;
    assign SPI_CPHA_o  = cpha_q;
    assign SPI_LSBFE_o = lsbfe_q;
    assign Busy_o      = (state_q != ST_IDLE);

endmodule
